// File: rtl/ser2par_frame_buf_if.sv
// Handshake bundle for ser2par_frame_buf.
// Input side:  in_valid/in_ready carry one DATA_W word per beat; in_last ends a frame early.
// Output side: out_valid/out_ready carry one DEPTH-word frame and its real word count.
// The slave modport is the collector's view; the master modport is the producer/consumer view.
interface ser2par_frame_buf_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W*DEPTH-1:0]   out_data;
  logic [CNT_W-1:0]          out_count;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/ser2par_frame_buf.sv
// Serial-to-parallel frame collector: packs DEPTH words of DATA_W bits into one
// flat frame (word i at bits [i*DATA_W +: DATA_W]) and presents it with a
// valid/ready handshake. Short frames end on in_last and are zero-padded.
// Ports: clk, rst (async, active-high), bus (ser2par_frame_buf_if.slave):
//   in_valid/in_ready/in_data/in_last, out_valid/out_ready/out_data/out_count.
// Optional macro SP2P_DOUBLE_BUF_EN: separate fill and output banks for
// sustained one word per cycle. Undefined: single bank, one idle cycle per frame.
module ser2par_frame_buf #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  ser2par_frame_buf_if.slave      bus
);
  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned FRAME_W = DATA_W * DEPTH;

  logic                 en;
  logic [IDX_W-1:0]     idx;
  logic [FRAME_W-1:0]   fill;
  logic [FRAME_W-1:0]   fill_next;
  logic                 out_valid_q;
  logic [CNT_W-1:0]     out_count_q;
  logic                 in_ready_c;
  logic                 accept;
  logic                 complete;
  logic [CNT_W-1:0]     beat_cnt;

  assign accept   = bus.in_valid && in_ready_c;
  assign complete = accept && (bus.in_last || (idx == IDX_W'(DEPTH - 1)));
  assign beat_cnt = CNT_W'(idx) + CNT_W'(1);

  // Fill image after this beat; slot 0 starts a frame, so older slots clear.
  always_comb begin
    fill_next = (idx == '0) ? '0 : fill;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (IDX_W'(i) == idx) fill_next[i*DATA_W +: DATA_W] = bus.in_data;
    end
  end

  // Enable comes up one edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) en <= 1'b0;
    else     en <= 1'b1;
  end

  // Fill index: advances per accepted beat, back to 0 on frame completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           idx <= '0;
    else if (complete) idx <= '0;
    else if (accept)   idx <= idx + IDX_W'(1);
  end

`ifdef SP2P_DOUBLE_BUF_EN
  logic                 fill_full;
  logic [CNT_W-1:0]     fill_cnt;
  logic [FRAME_W-1:0]   out_data_q;
  logic                 out_free;

  assign out_free   = !out_valid_q || bus.out_ready;
  assign in_ready_c = en && !fill_full;

  // Completed frames bypass to the output bank when it is free; otherwise
  // they park in the fill bank until the pending output is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill        <= '0;
      fill_full   <= 1'b0;
      fill_cnt    <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (complete) begin
        if (out_free) begin
          out_data_q  <= fill_next;
          out_count_q <= beat_cnt;
          out_valid_q <= 1'b1;
          fill        <= '0;
        end else begin
          fill      <= fill_next;
          fill_cnt  <= beat_cnt;
          fill_full <= 1'b1;
        end
      end else begin
        if (accept) fill <= fill_next;
        if (fill_full && bus.out_ready) begin
          out_data_q  <= fill;
          out_count_q <= fill_cnt;
          fill        <= '0;
          fill_full   <= 1'b0;
        end else if (out_valid_q && bus.out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.out_data = out_data_q;
`else
  assign in_ready_c = en && !out_valid_q;

  // Single bank: the fill storage is the output frame. No beat is accepted
  // while a frame is pending, so the frame stays stable until consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill        <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) fill <= fill_next;
      if (complete) begin
        out_valid_q <= 1'b1;
        out_count_q <= beat_cnt;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data = fill;
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
endmodule

// File: tb/tb_ser2par_frame_buf.sv
// Directed self-checking bench for ser2par_frame_buf (DEPTH=16/DATA_W=16 and DEPTH=4/DATA_W=8).
module tb_ser2par_frame_buf;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [255:0] exp_frame;
  logic [255:0] held_frame;

  always #5 clk = ~clk;

  ser2par_frame_buf_if #(.DATA_W(16), .DEPTH(16)) bus ();
  ser2par_frame_buf_if #(.DATA_W(8),  .DEPTH(4))  bus4 ();

  ser2par_frame_buf #(.DATA_W(16), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ser2par_frame_buf #(.DATA_W(8), .DEPTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("beat_timeout", 256'(n), 256'(0));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.in_data   = '0;
    bus4.in_last   = 1'b0;
    bus4.out_ready = 1'b1;

    // Reset state
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_out_data",  256'(bus.out_data),  256'(0));
    chk("rst_out_count", 256'(bus.out_count), 256'(0));
    chk("rst_in_ready",  256'(bus.in_ready),  256'(0));
    rst = 1'b0;
    #1 chk("post_rst_in_ready_before_edge", 256'(bus.in_ready), 256'(0));
    @(negedge clk);
    chk("enable_in_ready", 256'(bus.in_ready), 256'(1));

    // Full frame 0..15 with out_ready=1
    for (int i = 0; i < 16; i++) begin
      chk("full_no_early_valid", 256'(bus.out_valid), 256'(0));
      send_beat(16'(i), 1'b0);
    end
    exp_frame = '0;
    for (int i = 0; i < 16; i++) exp_frame[i*16 +: 16] = 16'(i);
    chk("full_out_valid", 256'(bus.out_valid), 256'(1));
    chk("full_out_count", 256'(bus.out_count), 256'(16));
    chk("full_out_data",  bus.out_data, exp_frame);
`ifndef SP2P_DOUBLE_BUF_EN
    chk("full_in_ready_low", 256'(bus.in_ready), 256'(0));
`endif
    @(negedge clk);
    chk("full_consumed", 256'(bus.out_valid), 256'(0));
    chk("full_in_ready_back", 256'(bus.in_ready), 256'(1));
`ifndef SP2P_DOUBLE_BUF_EN
    chk("full_data_kept", bus.out_data, exp_frame);
`endif

    // Short frame terminated by in_last
    send_beat(16'h00A1, 1'b0);
    send_beat(16'h00A2, 1'b0);
    send_beat(16'h00A3, 1'b1);
    chk("short_out_valid", 256'(bus.out_valid), 256'(1));
    chk("short_out_count", 256'(bus.out_count), 256'(3));
    chk("short_out_data",  bus.out_data, 256'h00A3_00A2_00A1);
    @(negedge clk);
    chk("short_consumed", 256'(bus.out_valid), 256'(0));
    // Next frame restarts at slot 0
    send_beat(16'h00B0, 1'b1);
    chk("restart_out_count", 256'(bus.out_count), 256'(1));
    chk("restart_out_data",  bus.out_data, 256'h00B0);
    @(negedge clk);

    // Back-pressure: hold frame for 10 cycles
    bus.out_ready = 1'b0;
    exp_frame = '0;
    for (int i = 0; i < 16; i++) begin
      exp_frame[i*16 +: 16] = 16'h0100 + 16'(i);
      send_beat(16'h0100 + 16'(i), 1'b0);
    end
    for (int c = 0; c < 10; c++) begin
      chk("bp_out_valid", 256'(bus.out_valid), 256'(1));
      chk("bp_out_count", 256'(bus.out_count), 256'(16));
      chk("bp_out_data",  bus.out_data, exp_frame);
`ifndef SP2P_DOUBLE_BUF_EN
      chk("bp_in_ready", 256'(bus.in_ready), 256'(0));
`endif
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 256'(bus.out_valid), 256'(0));

`ifdef SP2P_DOUBLE_BUF_EN
    // Sustained 64 beats, one per cycle
    for (int i = 0; i < 64; i++) begin
      chk("dbuf_in_ready", 256'(bus.in_ready), 256'(1));
      send_beat(16'h0400 + 16'(i), 1'b0);
      if ((i % 16) == 15) begin
        exp_frame = '0;
        for (int k = 0; k < 16; k++) exp_frame[k*16 +: 16] = 16'h0400 + 16'(i - 15 + k);
        chk("dbuf_out_valid", 256'(bus.out_valid), 256'(1));
        chk("dbuf_out_data",  bus.out_data, exp_frame);
      end else begin
        chk("dbuf_out_idle", 256'(bus.out_valid), 256'(0));
      end
    end
    @(negedge clk);
`endif

    // Reset mid-frame
    for (int i = 0; i < 7; i++) send_beat(16'h0200 + 16'(i), 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("midrst_out_data",  bus.out_data, 256'(0));
    chk("midrst_in_ready",  256'(bus.in_ready), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_post_in_ready", 256'(bus.in_ready), 256'(0));
    @(negedge clk);
    chk("midrst_enable", 256'(bus.in_ready), 256'(1));
    chk("midrst_no_valid", 256'(bus.out_valid), 256'(0));
    exp_frame = '0;
    for (int i = 0; i < 16; i++) begin
      exp_frame[i*16 +: 16] = 16'h0300 + 16'(i);
      send_beat(16'h0300 + 16'(i), 1'b0);
    end
    chk("midrst_new_count", 256'(bus.out_count), 256'(16));
    chk("midrst_new_data",  bus.out_data, exp_frame);
    @(negedge clk);

    // DEPTH=4, DATA_W=8 instance
    for (int i = 0; i < 4; i++) begin
      chk("d4_in_ready", 256'(bus4.in_ready), 256'(1));
      bus4.in_valid = 1'b1;
      bus4.in_data  = 8'(8'h11 * (i + 1));
      @(posedge clk);
      @(negedge clk);
    end
    bus4.in_valid = 1'b0;
    chk("d4_out_valid", 256'(bus4.out_valid), 256'(1));
    chk("d4_out_data",  256'(bus4.out_data),  256'h44332211);
    chk("d4_out_count", 256'(bus4.out_count), 256'(4));
    @(negedge clk);
    chk("d4_consumed", 256'(bus4.out_valid), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
